mem_mdr_unit: RTL

MEM_MDR_UNIT -- requirements
Module: mem_mdr_unit

---
 rtl/mem_mdr_pkg.sv | 15 +
 rtl/gp_register.sv | 17 +
 rtl/mem_mdr_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mem_mdr_pkg.sv
// Shared types and default parameters for the memory MAR/MDR unit.
package mem_mdr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_REQ = 2'd1,
    WR_REQ = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DEF_BITS           = 32;
  localparam int DEF_ADDR_BITS      = 9;
  localparam int DEF_TIMEOUT_CYCLES = 15;

endpackage

// File: rtl/gp_register.sv
// General-purpose register with load enable and asynchronous active-low clear.
module gp_register #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/mem_mdr_unit.sv
// MAR/MDR front end with a read/write handshake FSM toward memory.
// Optional ack timeout is built only when MEM_TIMEOUT_EN is defined.
//
// state  | meaning
// IDLE   | registers loadable, waiting for Read/Write
// RD_REQ | mem_rd high, waiting for ack to capture mem_rdata
// WR_REQ | mem_wr high, waiting for ack
// DONE   | one-cycle completion pulse (err set if timed out)
module mem_mdr_unit
  import mem_mdr_pkg::*;
#(
  parameter int BITS           = DEF_BITS,
  parameter int ADDR_BITS      = DEF_ADDR_BITS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 Clock,
  input  logic                 reset,
  input  logic [BITS-1:0]      bus_in,
  input  logic                 MARin,
  input  logic                 MDRin,
  input  logic                 Read,
  input  logic                 Write,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [BITS-1:0]      mem_wdata,
  output logic                 mem_rd,
  output logic                 mem_wr,
  input  logic [BITS-1:0]      mem_rdata,
  input  logic                 mem_ack,
  output logic [ADDR_BITS-1:0] MARVal,
  output logic [BITS-1:0]      MDRVal,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  state_t          state, state_nxt;
  logic            mar_en, mdr_en;
  logic [BITS-1:0] mdr_d;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             timeout_hit, err_q;
`endif

  // Loads in IDLE land on the same edge that leaves IDLE, so a transfer
  // started together with MARin/MDRin already sees the new values.
  assign mdr_d = (state == RD_REQ) ? mem_rdata : bus_in;

  always_comb begin
    state_nxt = state;
    mar_en    = 1'b0;
    mdr_en    = 1'b0;
    case (state)
      IDLE: begin
        mar_en = MARin;
        mdr_en = MDRin;
        if (Read)       state_nxt = RD_REQ;
        else if (Write) state_nxt = WR_REQ;
      end
      RD_REQ: begin
        if (mem_ack) begin
          mdr_en    = 1'b1;
          state_nxt = DONE;
        end
      end
      WR_REQ: begin
        if (mem_ack) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  // Counter idles at zero, so it is already clear on entry to a request
  // state; an ack on the limit cycle wins over the timeout.
  always_comb begin
    cnt_nxt     = '0;
    timeout_hit = 1'b0;
    if ((state == RD_REQ || state == WR_REQ) && !mem_ack) begin
      if (cnt == CNT_LIM) timeout_hit = 1'b1;
      else                cnt_nxt     = cnt + 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      err_q <= timeout_hit;
    end
  end
`endif

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) state <= IDLE;
`ifdef MEM_TIMEOUT_EN
    else if (timeout_hit) state <= DONE;
`endif
    else state <= state_nxt;
  end

  gp_register #(.W(ADDR_BITS)) u_mar (
    .clk   (Clock),
    .clr_n (reset),
    .en    (mar_en),
    .d     (bus_in[ADDR_BITS-1:0]),
    .q     (MARVal)
  );

  gp_register #(.W(BITS)) u_mdr (
    .clk   (Clock),
    .clr_n (reset),
    .en    (mdr_en),
    .d     (mdr_d),
    .q     (MDRVal)
  );

  assign mem_addr  = MARVal;
  assign mem_wdata = MDRVal;
  assign mem_rd    = (state == RD_REQ);
  assign mem_wr    = (state == WR_REQ);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
`ifdef MEM_TIMEOUT_EN
  assign err       = err_q && (state == DONE);
`else
  assign err       = 1'b0;
`endif

endmodule
